sum_arbiter: RTL and testbench
==============================

// Module: sum_arbiter
// PURPOSE
//   Shares the single combinational 'sum' adder among up to N_REQ sequential datapath
//   units, e.g. several 'mul' instances driving sum_in_a/sum_in_b and reading sum_out.
//   - Round-robin arbiter with a lock: the owner keeps the adder for as long as its req is high.
//   - Muxes the owner's operands onto the adder and broadcasts the adder result to all units.
//   - Sits between the requester array and one 'sum' instance.
// PARAMETERS
//   N_REQ  4   number of requesters (2..8)
//   WIDTH  16  operand/result width; must match 'sum'
//   CNT_W  16  width of the utilisation counter (SUM_ARB_UTIL_EN builds only)
// PORTS
//   clk       in   1            single clock, rising edge
//   rst       in   1            synchronous, active-low reset (0 = reset, sampled on posedge clk)
//   req       in   N_REQ        req[i]=1: unit i wants or holds the adder
//   op_a      in   N_REQ*WIDTH  packed operand A; unit i uses bits [i*WIDTH +: WIDTH]
//   op_b      in   N_REQ*WIDTH  packed operand B, same packing as op_a
//   gnt       out  N_REQ        registered one-hot grant (all-zero when idle)
//   res       out  WIDTH        adder result broadcast to all units; valid only for granted unit
//   busy      out  1            1 while any grant is active (|gnt)
//   sum_a     out  WIDTH        to sum.a
//   sum_b     out  WIDTH        to sum.b
//   sum_res   in   WIDTH        from sum.result
//   util_cnt  out  CNT_W        granted-cycle count (SUM_ARB_UTIL_EN only)
// BEHAVIOUR
//   Reset (rst=0 at posedge):
//     - gnt=0, busy=0, state=IDLE, util_cnt=0.
//     - Round-robin pointer ptr=0, so unit 0 has top priority for the first grant.
//   States:
//     - IDLE: no owner.
//     - OWNED: one-hot gnt[k]=1, where k is the owner.
//   Arbitration (at posedge, when state=IDLE, or state=OWNED with req[k]=0):
//     - Scan req from index ptr upward, wrapping modulo N_REQ; the first set bit j wins.
//     - Winner j: gnt<=onehot(j), ptr<=(j+1)%N_REQ, state=OWNED.
//     - No req set: gnt<=0, state=IDLE; ptr unchanged.
//   Latency: req[i] first seen high at edge E -> gnt[i]=1 after E, if free and i wins.
//   Lock: in OWNED, while req[k]=1, gnt stays onehot(k) regardless of other reqs.
//     No preemption and no hold limit.
//   Handoff:
//     - Owner drops req[k] at edge E while others request: the next grant is issued
//       at E itself, with zero idle cycles between owners.
//     - The scan starts at k+1, so the releasing unit ranks lowest.
//   Release with no other requester: IDLE after E; busy=0 in the following cycle.
//   req[i] set while another unit owns the adder: unit i waits, with no timeout;
//     it is guaranteed service within N_REQ-1 ownerships.
//   Datapath (combinational from registered gnt):
//     - sum_a/sum_b = op_a/op_b slice of the owner; all-zero when IDLE.
//     - res = sum_res, unmodified; the adder wraps modulo 2^WIDTH and its carry is dropped.
//   Mid-operation reset: gnt clears at that edge. Requesters are responsible for
//     aborting their own ops.
//   X/undefined req bits are not tolerated: the bench drives req to 0 or 1 out of reset.
// CONFIGURATION
//   `define SUM_ARB_UTIL_EN (compiled in):
//     - util_cnt increments on every posedge where busy=1 and rst=1.
//     - util_cnt saturates at 2^CNT_W-1 and clears only on reset.
//   SUM_ARB_UTIL_EN not defined (compiled out):
//     - util_cnt is absent from the port list; no counter logic is built.
//     - All other behaviour is identical.
// TESTING (N_REQ=4, WIDTH=16; each step is one clock edge)
//   1. Single request: reset, then req=0001, op_a[0]=3, op_b[0]=2 at edge E.
//      -> gnt=0001 after E; sum_a=3, sum_b=2, res=5; drop req -> gnt=0000, busy=0 after next edge.
//   2. Contention: req=1111 held from reset release.
//      -> gnt 0001 is granted first; while req[0] stays high, gnt stays 0001 for 10 cycles.
//   3. Round-robin handoff: with req=1111, drop each owner's req for one cycle in turn.
//      -> gnt sequence is 0001, 0010, 0100, 1000, 0001, with no IDLE cycle between owners.
//   4. Wrap-around: owner 3 releases while req=0101.
//      -> next gnt=0001, then 0100 after unit 0 releases; operands 0xFFFF+0x0001 -> res=0x0000.
//   5. Reset mid-op: gnt=0100 and rst=0 for one edge.
//      -> gnt=0000, busy=0, util_cnt=0; with req=0110 after reset, unit 1 wins (ptr=0 scan).
//   6. SUM_ARB_UTIL_EN: 7 granted cycles then idle -> util_cnt=7 and holds;
//      with CNT_W=3 and 10 granted cycles -> util_cnt=7 (saturated).

Source files
------------

// File: rtl/sum_arbiter.sv
// rtl/sum_arbiter.sv - round-robin locking arbiter sharing one adder among N_REQ units
// Optional utilisation counter: define SUM_ARB_UTIL_EN to build util_cnt.
module sum_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
`ifdef SUM_ARB_UTIL_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       res,
    output logic                   busy,
    output logic [WIDTH-1:0]       sum_a,
    output logic [WIDTH-1:0]       sum_b,
    input  logic [WIDTH-1:0]       sum_res
`ifdef SUM_ARB_UTIL_EN
    ,
    output logic [CNT_W-1:0]       util_cnt
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]       state;
    logic [PTR_W-1:0] ptr;
    logic             hold;
    logic             found;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] ptr_next;
    int               idx;

    // Owner keeps the adder while its own req stays high.
    assign hold = |(gnt & req);

    // Rotating scan starting at ptr; first requester found wins.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = 0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (int'(ptr) + off) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    assign ptr_next = PTR_W'((int'(win) + 1) % N_REQ);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            gnt   <= '0;
            ptr   <= '0;
        end else if (state == ST_IDLE || !hold) begin
            if (found) begin
                gnt      <= '0;
                gnt[win] <= 1'b1;
                ptr      <= ptr_next;
                state    <= ST_OWNED;
            end else begin
                gnt   <= '0;
                state <= ST_IDLE;
            end
        end
    end

    assign busy = |gnt;

    // One-hot grant makes an OR-mux sufficient; idle drives zero operands.
    always_comb begin
        sum_a = '0;
        sum_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sum_a = sum_a | op_a[i*WIDTH +: WIDTH];
                sum_b = sum_b | op_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign res = sum_res;

`ifdef SUM_ARB_UTIL_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            util_cnt <= '0;
        end else if (busy && util_cnt != {CNT_W{1'b1}}) begin
            util_cnt <= util_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sum_arbiter.sv
// tb/tb_sum_arbiter.sv - scoreboard bench for sum_arbiter (N_REQ=4, WIDTH=16)
module tb_sum_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [3:0]  gnt;
    logic [15:0] res;
    logic        busy;
    logic [15:0] sum_a;
    logic [15:0] sum_b;
    logic [15:0] sum_res;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [3:0]  gnt;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        int          eu;
        int          eu3;
    } exp_t;

    exp_t q[$];

    // The shared 'sum' instance: plain wrapping adder.
    assign sum_res = sum_a + sum_b;

`ifdef SUM_ARB_UTIL_EN
    logic [15:0] util_cnt;
    logic [3:0]  gnt3;
    logic [15:0] res3;
    logic        busy3;
    logic [15:0] sum_a3;
    logic [15:0] sum_b3;
    logic [2:0]  util_cnt3;

    sum_arbiter #(.N_REQ(4), .WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .res(res), .busy(busy), .sum_a(sum_a), .sum_b(sum_b),
        .sum_res(sum_res), .util_cnt(util_cnt)
    );

    sum_arbiter #(.N_REQ(4), .WIDTH(16), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt3), .res(res3), .busy(busy3), .sum_a(sum_a3), .sum_b(sum_b3),
        .sum_res(sum_a3 + sum_b3), .util_cnt(util_cnt3)
    );
`else
    sum_arbiter #(.N_REQ(4), .WIDTH(16)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .res(res), .busy(busy), .sum_a(sum_a), .sum_b(sum_b),
        .sum_res(sum_res)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic step(input logic r_rst, input logic [3:0] r, input logic [3:0] eg,
                        input string nm, input int eu = -1, input int eu3 = -1);
        exp_t e;
        @(negedge clk);
        rst = r_rst;
        req = r;
        e.name = nm;
        e.gnt  = eg;
        e.a    = '0;
        e.b    = '0;
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) begin
                e.a = op_a[i*16 +: 16];
                e.b = op_b[i*16 +: 16];
            end
        end
        e.r   = e.a + e.b;
        e.eu  = eu;
        e.eu3 = eu3;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.name, "_gnt"},   32'(gnt),   32'(e.gnt));
                chk({e.name, "_busy"},  32'(busy),  32'(|e.gnt));
                chk({e.name, "_sum_a"}, 32'(sum_a), 32'(e.a));
                chk({e.name, "_sum_b"}, 32'(sum_b), 32'(e.b));
                chk({e.name, "_res"},   32'(res),   32'(e.r));
`ifdef SUM_ARB_UTIL_EN
                if (e.eu >= 0)  chk({e.name, "_util"},  32'(util_cnt),  32'(e.eu));
                if (e.eu3 >= 0) chk({e.name, "_util3"}, 32'(util_cnt3), 32'(e.eu3));
`endif
            end
        end
    end

    initial begin : driver
        rst  = 1'b0;
        req  = 4'b0000;
        // unit:        3          2          1          0
        op_a = {16'h7000, 16'hFFFF, 16'h0010, 16'h0003};
        op_b = {16'h9001, 16'h0001, 16'h0020, 16'h0002};

        step(1'b0, 4'b0000, 4'b0000, "reset", 0, 0);
        step(1'b0, 4'b0000, 4'b0000, "reset2", 0, 0);

        // single request: 3 + 2 = 5
        step(1'b1, 4'b0001, 4'b0001, "t1_grant");
        step(1'b1, 4'b0000, 4'b0000, "t1_release");

        // contention from reset release: unit 0 wins and keeps the lock
        step(1'b0, 4'b1111, 4'b0000, "t2_reset");
        repeat (10) step(1'b1, 4'b1111, 4'b0001, "t2_lock");

        // round-robin handoff with no idle cycle
        step(1'b1, 4'b1110, 4'b0010, "t3_h1");
        step(1'b1, 4'b1111, 4'b0010, "t3_k1");
        step(1'b1, 4'b1101, 4'b0100, "t3_h2");
        step(1'b1, 4'b1111, 4'b0100, "t3_k2");
        step(1'b1, 4'b1011, 4'b1000, "t3_h3");
        step(1'b1, 4'b1111, 4'b1000, "t3_k3");
        step(1'b1, 4'b0111, 4'b0001, "t3_h0");
        step(1'b1, 4'b1111, 4'b0001, "t3_k0");

        // wrap-around; unit 2 computes 0xFFFF + 0x0001 = 0
        step(1'b1, 4'b1000, 4'b1000, "t4_own3");
        step(1'b1, 4'b0101, 4'b0001, "t4_wrap");
        step(1'b1, 4'b0100, 4'b0100, "t4_unit2");

        // reset mid-op, then ptr restarts at 0
        step(1'b0, 4'b0100, 4'b0000, "t5_reset", 0, 0);
        step(1'b1, 4'b0110, 4'b0010, "t5_ptr0");
        step(1'b1, 4'b0000, 4'b0000, "t5_idle");

        // utilisation: 7 busy cycles, then saturation of the 3-bit counter
        step(1'b0, 4'b0000, 4'b0000, "u_reset", 0, 0);
        repeat (7) step(1'b1, 4'b0001, 4'b0001, "u_busy");
        step(1'b1, 4'b0000, 4'b0000, "u_seven", 7, 7);
        step(1'b1, 4'b0000, 4'b0000, "u_hold", 7, 7);
        step(1'b0, 4'b0000, 4'b0000, "u_reset2", 0, 0);
        repeat (10) step(1'b1, 4'b0001, 4'b0001, "u_sat");
        step(1'b1, 4'b0000, 4'b0000, "u_ten", 10, 7);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
